// File: rtl/bfcpu_bus_sequencer_if.sv
// CPU-side request and host-side pin bus signals of the BF CPU bus sequencer.
// master is the CPU plus host environment; slave is the sequencer.
interface bfcpu_bus_sequencer_if;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        mreq;
    logic [2:0]  mtype;
    logic        mdone;
    logic        ack;
    logic        rdy;
    logic [1:0]  bus_ctrl;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;

    modport master (
        output addr, data_in, mreq, mtype, ack, bus_in,
        input  data_out, mdone, rdy, bus_ctrl, bus_out
    );

    modport slave (
        input  addr, data_in, mreq, mtype, ack, bus_in,
        output data_out, mdone, rdy, bus_ctrl, bus_out
    );
endinterface

// File: rtl/bfcpu_bus_sequencer.sv
// Serialises one CPU memory/IO request into rdy/ack handshaked beats on the
// shared 8-bit pin bus and returns the DATA_IN byte on data_out.
module bfcpu_bus_sequencer #(
    parameter int unsigned ACK_SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  reset,
    bfcpu_bus_sequencer_if.slave bus
);
    localparam logic [2:0] T_RDATA = 3'd2;
    localparam logic [2:0] T_WDATA = 3'd3;
    localparam logic [2:0] T_WCHAR = 3'd5;

    localparam logic [1:0] B_ADDR_LO  = 2'd0;
    localparam logic [1:0] B_ADDR_HI  = 2'd1;
    localparam logic [1:0] B_DATA_OUT = 2'd2;
    localparam logic [1:0] B_DATA_IN  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, BEAT_REQ, BEAT_REL, DONE, WAIT_REL
    } state_t;

    state_t                     state;
    logic [2:0]                 mtype_l;
    logic [15:0]                addr_l;
    logic [7:0]                 data_l;
    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic                       ack_s;
    logic [1:0]                 first_kind;
    logic [1:0]                 next_kind;

    // ack is asynchronous to clk; only the last stage is used
    if (ACK_SYNC_STAGES == 1) begin : g_sync_one
        always_ff @(posedge clk) begin
            if (reset) ack_sync <= '0;
            else       ack_sync <= bus.ack;
        end
    end else begin : g_sync_many
        always_ff @(posedge clk) begin
            if (reset) ack_sync <= '0;
            else       ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], bus.ack};
        end
    end
    assign ack_s = ack_sync[ACK_SYNC_STAGES-1];

    function automatic logic [7:0] beat_byte(logic [1:0] kind, logic [15:0] a, logic [7:0] d);
        case (kind)
            B_ADDR_LO:  return a[7:0];
            B_ADDR_HI:  return a[15:8];
            B_DATA_OUT: return d;
            default:    return 8'h00;
        endcase
    endfunction

    // Address-carrying types start at ADDR_LO; DATA_OUT/DATA_IN always end a sequence
    always_comb begin
        first_kind = B_DATA_IN;
        if (bus.mtype == T_RDATA || bus.mtype == T_WDATA) first_kind = B_ADDR_LO;
        else if (bus.mtype == T_WCHAR)                    first_kind = B_DATA_OUT;
        next_kind = B_ADDR_HI;
        if (bus.bus_ctrl == B_ADDR_HI)
            next_kind = (mtype_l == T_WDATA) ? B_DATA_OUT : B_DATA_IN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mtype_l      <= '0;
            addr_l       <= '0;
            data_l       <= '0;
            bus.rdy      <= 1'b0;
            bus.mdone    <= 1'b0;
            bus.bus_ctrl <= '0;
            bus.bus_out  <= '0;
            bus.data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mreq) begin
                        mtype_l <= bus.mtype;
                        addr_l  <= bus.addr;
                        data_l  <= bus.data_in;
                        if (bus.mtype[2:1] == 2'b11) begin
                            bus.mdone <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus.bus_ctrl <= first_kind;
                            bus.bus_out  <= beat_byte(first_kind, bus.addr, bus.data_in);
                            bus.rdy      <= 1'b1;
                            state        <= BEAT_REQ;
                        end
                    end
                end
                BEAT_REQ: begin
                    if (ack_s) begin
                        if (bus.bus_ctrl == B_DATA_IN) bus.data_out <= bus.bus_in;
                        bus.rdy <= 1'b0;
                        state   <= BEAT_REL;
                    end
                end
                BEAT_REL: begin
                    if (!ack_s) begin
                        if (bus.bus_ctrl[1]) begin
                            bus.mdone <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus.bus_ctrl <= next_kind;
                            bus.bus_out  <= beat_byte(next_kind, addr_l, data_l);
                            bus.rdy      <= 1'b1;
                            state        <= BEAT_REQ;
                        end
                    end
                end
                DONE: begin
                    bus.mdone <= 1'b0;
                    state     <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!bus.mreq) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bfcpu_bus_sequencer.sv
// Randomised self-checking bench for bfcpu_bus_sequencer with a transaction-level
// reference model of the beat sequences and a bench-driven host.
module tb_bfcpu_bus_sequencer;
    logic clk;
    logic reset;
    int   vectors = 0;
    int   fails   = 0;
    int   rdy_rises = 0;
    int   mdone_cnt = 0;
    logic rdy_prev  = 1'b0;
    logic [7:0] exp_dout = 8'h00;

    bfcpu_bus_sequencer_if bus ();

    bfcpu_bus_sequencer #(.ACK_SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rdy && !rdy_prev) rdy_rises = rdy_rises + 1;
        rdy_prev = bus.rdy;
        if (bus.mdone) mdone_cnt = mdone_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_rdy(input logic level, output bit ok);
        int n = 0;
        while (bus.rdy !== level && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.rdy === level);
    endtask

    // Reference: beat list of a request from its type alone
    task automatic model_beats(input logic [2:0] mt, input logic [15:0] a, input logic [7:0] d,
                               output int nb, output logic [1:0] ec[3], output logic [7:0] eo[3]);
        ec = '{2'd0, 2'd0, 2'd0};
        eo = '{8'h00, 8'h00, 8'h00};
        case (mt)
            3'd0, 3'd1, 3'd4: begin nb = 1; ec[0] = 2'd3; end
            3'd2: begin nb = 3; ec = '{2'd0, 2'd1, 2'd3}; eo = '{a[7:0], a[15:8], 8'h00}; end
            3'd3: begin nb = 3; ec = '{2'd0, 2'd1, 2'd2}; eo = '{a[7:0], a[15:8], d}; end
            3'd5: begin nb = 1; ec[0] = 2'd2; eo[0] = d; end
            default: nb = 0;
        endcase
    endtask

    task automatic run_txn(input logic [2:0] mt, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] hbyte, input int rise_dly, input int fall_dly,
                           input bit toggle);
        int nb, rises0, dones0, dly, n;
        logic [1:0] ec[3];
        logic [7:0] eo[3];
        bit ok;
        model_beats(mt, a, d, nb, ec, eo);
        @(negedge clk);
        bus.mtype = mt; bus.addr = a; bus.data_in = d; bus.mreq = 1'b1;
        rises0 = rdy_rises;
        dones0 = mdone_cnt;
        for (int i = 0; i < nb; i++) begin
            wait_rdy(1'b1, ok);
            check("rdy_rise", 32'(ok), 32'd1);
            check("bus_ctrl", 32'(bus.bus_ctrl), 32'(ec[i]));
            check("bus_out", 32'(bus.bus_out), 32'(eo[i]));
            if (toggle) begin
                bus.addr    = 16'($urandom);
                bus.data_in = 8'($urandom);
                bus.mtype   = 3'($urandom);
            end
            bus.bus_in = (ec[i] == 2'd3) ? hbyte : 8'($urandom);
            dly = (rise_dly < 0) ? int'($urandom_range(0, 4)) : rise_dly;
            repeat (dly) @(negedge clk);
            check("rdy_hold", 32'(bus.rdy), 32'd1);
            bus.ack = 1'b1;
            wait_rdy(1'b0, ok);
            check("rdy_fall", 32'(ok), 32'd1);
            if (ec[i] == 2'd3) exp_dout = hbyte;
            check("data_out", 32'(bus.data_out), 32'(exp_dout));
            bus.bus_in = 8'($urandom);
            dly = (fall_dly < 0) ? int'($urandom_range(0, 4)) : fall_dly;
            repeat (dly) @(negedge clk);
            bus.ack = 1'b0;
        end
        n = 0;
        while (bus.mdone !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mdone_seen", 32'(bus.mdone), 32'd1);
        check("data_out_done", 32'(bus.data_out), 32'(exp_dout));
        if (nb > 0) begin
            check("ctrl_hold", 32'(bus.bus_ctrl), 32'(ec[nb-1]));
            check("out_hold", 32'(bus.bus_out), 32'(eo[nb-1]));
        end
        repeat (5) @(negedge clk);
        check("beat_count", 32'(rdy_rises - rises0), 32'(nb));
        check("mdone_count", 32'(mdone_cnt - dones0), 32'd1);
        check("no_retrigger", 32'(bus.rdy), 32'd0);
        bus.mreq = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dones0;
        bit ok;
        reset = 1'b1;
        bus.mreq = 1'b1; bus.mtype = 3'd0; bus.addr = 16'h0; bus.data_in = 8'h0;
        bus.ack = 1'b0; bus.bus_in = 8'h0;
        repeat (4) begin
            @(negedge clk);
            check("rst_rdy", 32'(bus.rdy), 32'd0);
            check("rst_mdone", 32'(bus.mdone), 32'd0);
            check("rst_data_out", 32'(bus.data_out), 32'd0);
            check("rst_bus_out", 32'(bus.bus_out), 32'd0);
            check("rst_bus_ctrl", 32'(bus.bus_ctrl), 32'd0);
        end
        reset = 1'b0;

        run_txn(3'd0, 16'($urandom), 8'($urandom), 8'h2B, -1, -1, 1'b0);
        run_txn(3'd3, 16'h1234, 8'hA5, 8'h00, -1, -1, 1'b0);
        run_txn(3'd2, 16'h7FFF, 8'h11, 8'h00, 0, 0, 1'b0);
        run_txn(3'd4, 16'h0000, 8'h22, 8'h41, -1, -1, 1'b0);
        run_txn(3'd3, 16'hBEEF, 8'h5A, 8'h00, 20, 5, 1'b1);
        run_txn(3'd2, 16'hC0DE, 8'h33, 8'h9C, 20, 5, 1'b1);

        // reset during BEAT_REQ of a WDATA aborts with no completion
        @(negedge clk);
        bus.mtype = 3'd3; bus.addr = 16'h4321; bus.data_in = 8'h77; bus.mreq = 1'b1;
        dones0 = mdone_cnt;
        wait_rdy(1'b1, ok);
        check("abort_rdy_up", 32'(ok), 32'd1);
        reset = 1'b1;
        bus.mreq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_dout = 8'h00;
        check("abort_rdy", 32'(bus.rdy), 32'd0);
        check("abort_data_out", 32'(bus.data_out), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_mdone", 32'(mdone_cnt - dones0), 32'd0);
        check("abort_idle_rdy", 32'(bus.rdy), 32'd0);

        run_txn(3'd7, 16'h5555, 8'h66, 8'h00, -1, -1, 1'b0);
        run_txn(3'd6, 16'hAAAA, 8'h99, 8'h00, -1, -1, 1'b0);

        for (int k = 0; k < 40; k++)
            run_txn(3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), -1, -1,
                    1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
